// File: rtl/hex_overlay_ctrl.sv
// Hex overlay sequencer: buffers one CPU value and copies it nibble by nibble
// into c1..c8 after a synchronized frame edge, so the display never tears.
module hex_overlay_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic        freeze,
    output logic [3:0]  c1,
    output logic [3:0]  c2,
    output logic [3:0]  c3,
    output logic [3:0]  c4,
    output logic [3:0]  c5,
    output logic [3:0]  c6,
    output logic [3:0]  c7,
    output logic [3:0]  c8,
    output logic        busy,
    output logic        update_done,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t                 state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   frame_edge_s;
    logic [31:0]            pend_data_r;
    logic                   pending_r;
    logic [31:0]            shadow_r;
    logic [31:0]            disp_r;
    logic [2:0]             idx_r;
    logic                   accept_s;
    logic [4:0]             lsb_s;

    // Frame strobe synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], frame_clk};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge strobe, write handshake and the LSB of the nibble being copied (MSB first).
    always_comb begin
        frame_edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;
        accept_s     = wr_en & ~pending_r;
        lsb_s        = 5'd28 - {idx_r, 2'b00};
    end

    assign wr_ready = ~pending_r;

    // Pending buffer, commit FSM, nibble copy and drop accounting.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            pend_data_r <= 32'h0000_0000;
            pending_r   <= 1'b0;
            shadow_r    <= 32'h0000_0000;
            disp_r      <= RESET_VALUE;
            idx_r       <= 3'd0;
            busy        <= 1'b0;
            update_done <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            update_done <= 1'b0;
            if (accept_s) begin
                pend_data_r <= wr_data;
                pending_r   <= 1'b1;
            end else begin
                pend_data_r <= pend_data_r;
            end
            case (state_r)
                IDLE: begin
                    if (frame_edge_s && pending_r && !freeze) begin
                        shadow_r  <= pend_data_r;
                        pending_r <= 1'b0;
                        idx_r     <= 3'd0;
                        busy      <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    disp_r[lsb_s +: 4] <= shadow_r[lsb_s +: 4];
                    idx_r              <= idx_r + 3'd1;
                    // A frame went by while a newer value was still waiting.
                    if (frame_edge_s && pending_r && (drop_cnt != 8'hFF)) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end else begin
                        drop_cnt <= drop_cnt;
                    end
                    if (idx_r == 3'd7) begin
                        update_done <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign c1 = disp_r[31:28];
    assign c2 = disp_r[27:24];
    assign c3 = disp_r[23:20];
    assign c4 = disp_r[19:16];
    assign c5 = disp_r[15:12];
    assign c6 = disp_r[11:8];
    assign c7 = disp_r[7:4];
    assign c8 = disp_r[3:0];

endmodule
